// File: rtl/addsub_arbiter.sv
// Two-requester front end for a shared 4-bit adder/subtractor: registered
// req/ack handshake, round-robin tie break, programmable settle wait, tagged result.

module adder_subtractor_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sel,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] sum;

  // Subtract as A + ~B + 1, so cout=1 means no borrow.
  assign sum  = {1'b0, a} + {1'b0, b ^ {4{sel}}} + {4'b0, sel};
  assign s    = sum[3:0];
  assign cout = sum[4];
endmodule

module addsub_arbiter #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic       sel0,
  input  logic       req1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic       sel1,
  output logic       ack0,
  output logic       ack1,
  output logic       busy,
  output logic       res_valid,
  output logic       res_id,
  output logic [3:0] res,
  output logic       res_cout,
  output logic       res_ovf
);
  typedef enum logic {IDLE, SETTLE} state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       sel;
  } op_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  op_t        op_q;
  logic       owner_q;
  logic       last_gnt;
  logic [3:0] cnt;
  logic       gnt_id;
  logic [3:0] add_s;
  logic       add_cout;
  logic       ovf;

  // Requester 1 wins when alone or on a tie it did not win last time.
  always_comb begin
    gnt_id = 1'b0;
    if (req1 && (!req0 || !last_gnt))
      gnt_id = 1'b1;
  end

  adder_subtractor_4bit u_addsub (
    .a    (op_q.a),
    .b    (op_q.b),
    .sel  (op_q.sel),
    .s    (add_s),
    .cout (add_cout)
  );

  assign ovf = op_q.sel ? ((op_q.a[3] != op_q.b[3]) && (add_s[3] != op_q.a[3]))
                        : ((op_q.a[3] == op_q.b[3]) && (add_s[3] != op_q.a[3]));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= '0;
      owner_q   <= 1'b0;
      last_gnt  <= 1'b1;
      cnt       <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res       <= '0;
      res_cout  <= 1'b0;
      res_ovf   <= 1'b0;
    end else begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            op_q     <= gnt_id ? op_t'{a1, b1, sel1} : op_t'{a0, b0, sel0};
            owner_q  <= gnt_id;
            last_gnt <= gnt_id;
            ack0     <= !gnt_id;
            ack1     <= gnt_id;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == CNT_LAST) begin
            res       <= add_s;
            res_cout  <= add_cout;
            res_ovf   <= ovf;
            res_id    <= owner_q;
            res_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with SETTLE_CYCLES=2 and hand-computed results.

module tb_addsub_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, sel0, sel1;
  logic [3:0] a0, b0, a1, b1;
  logic       ack0, ack1, busy, res_valid, res_id, res_cout, res_ovf;
  logic [3:0] res;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  addsub_arbiter #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .sel0(sel0),
    .req1(req1), .a1(a1), .b1(b1), .sel1(sel1),
    .ack0(ack0), .ack1(ack1), .busy(busy), .res_valid(res_valid),
    .res_id(res_id), .res(res), .res_cout(res_cout), .res_ovf(res_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One request through the handshake; optionally disturbs the operand after ack.
  task automatic run_op(input logic id, input logic [3:0] a, input logic [3:0] b,
                        input logic sel, input logic [3:0] e_res, input logic e_cout,
                        input logic e_ovf, input logic chg_a);
    int n;
    logic seen;
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; sel1 = sel; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; sel0 = sel; end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = id ? ack1 : ack0;
    end
    chk("ack_seen", 32'(seen), 32'd1);
    chk("busy_at_ack", 32'(busy), 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    if (chg_a) begin a0 = 4'b1111; a1 = 4'b1111; end
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      n++;
      if (n == 1) chk("ack_pulse", 32'({ack0, ack1}), 32'd0);
      seen = res_valid;
    end
    chk("res_valid_lat", 32'(n), 32'd2);
    chk("res", 32'(res), 32'(e_res));
    chk("res_cout", 32'(res_cout), 32'(e_cout));
    chk("res_ovf", 32'(res_ovf), 32'(e_ovf));
    chk("res_id", 32'(res_id), 32'(id));
    chk("busy_at_valid", 32'(busy), 32'd0);
    tick();
    chk("valid_pulse", 32'(res_valid), 32'd0);
  endtask

  initial begin
    int g_id[$];
    int g_cyc[$];
    logic seen;
    rst = 1'b1; req0 = 0; req1 = 0; a0 = 0; b0 = 0; sel0 = 0; a1 = 0; b1 = 0; sel1 = 0;
    tick();
    do_reset();

    for (int i = 0; i < 10; i++) begin
      chk("idle_outputs", 32'({ack0, ack1, busy, res_valid, res_id, res, res_cout, res_ovf}), 32'd0);
      tick();
    end

    run_op(1'b0, 4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0);
    run_op(1'b1, 4'b1111, 4'b1010, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b0);
    run_op(1'b1, 4'b0111, 4'b1000, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b0);
    run_op(1'b0, 4'b1001, 4'b1010, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);

    // Continuous tie: grants alternate starting with requester 0.
    do_reset();
    req0 = 1; a0 = 4'b0010; b0 = 4'b0001; sel0 = 1;
    req1 = 1; a1 = 4'b0001; b1 = 4'b0010; sel1 = 1;
    for (int c = 0; c < 13; c++) begin
      tick();
      if (ack0) begin g_id.push_back(0); g_cyc.push_back(c); end
      if (ack1) begin g_id.push_back(1); g_cyc.push_back(c); end
      if (res_valid) begin
        if (res_id) begin
          chk("tie_res1", 32'({res, res_cout, res_ovf}), 32'({4'b1111, 1'b0, 1'b0}));
        end else begin
          chk("tie_res0", 32'({res, res_cout, res_ovf}), 32'({4'b0001, 1'b1, 1'b0}));
        end
      end
    end
    req0 = 0; req1 = 0;
    chk("tie_grants", 32'(g_id.size()), 32'd5);
    for (int k = 0; k < g_id.size() && k < 5; k++) begin
      chk("tie_order", 32'(g_id[k]), 32'(k % 2));
      if (k > 0) chk("tie_spacing", 32'(g_cyc[k] - g_cyc[k-1]), 32'd3);
    end

    // Reset while busy: no result, then tie goes to requester 0.
    tick(); tick();
    req0 = 1; a0 = 4'b0001; b0 = 4'b0001; sel0 = 0;
    tick();
    chk("rst_ack0", 32'(ack0), 32'd1);
    req0 = 0;
    chk("rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen |= res_valid | busy | ack0 | ack1;
      tick();
    end
    chk("rst_abort", 32'(seen), 32'd0);
    req0 = 1; req1 = 1;
    tick();
    chk("rst_tie_gnt", 32'({ack0, ack1}), 32'b10);
    req0 = 0; req1 = 0;
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

- Shares one `adder_subtractor_4bit` instance between two requesters with a registered request/acknowledge handshake and round-robin arbitration on ties.
- Latches the winner's operands into internal registers and drives the adder from those registers.
- Waits a programmable number of settle cycles, so both the zero-delay and the gate-delay adder variants are covered.
- Returns a registered result tagged with the requester ID. Sits between the lab's sequential control logic and the combinational adder/subtractor datapath.

## Interface
- `SETTLE_CYCLES`, default 2: clock edges between operand latch and result capture. Legal range is 1..15.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0`  in  1  requester 0 operation request. Held high until `ack0`.
- `a0`  in  4  requester 0 operand A, two's complement.
- `b0`  in  4  requester 0 operand B, two's complement.
- `sel0`  in  1  requester 0 op: 0 = A+B, 1 = A−B.
- `req1`, `a1`, `b1`, `sel1`: same as above, for requester 1.
- `ack0`  out  1  one-cycle pulse: requester 0 operands latched.
- `ack1`  out  1  one-cycle pulse: requester 1 operands latched.
- `busy`  out  1  operation in flight; no request is sampled.
- `res_valid`  out  1  one-cycle pulse: result fields valid.
- `res_id`  out  1  requester that owns the current result.
- `res`  out  4  4-bit sum/difference.
- `res_cout`  out  1  adder carry-out.
- `res_ovf`  out  1  signed overflow.

## Operation
- States: IDLE and SETTLE.
- IDLE, on a rising edge:
  - Neither req: stay in IDLE.
  - Exactly one req: grant it.
  - Both reqs: grant the requester ≠ `last_gnt`.
  - On grant: latch {a, b, sel} into op registers; set `last_gnt` = winner; assert that ack for the next cycle; clear `cnt`; go to SETTLE.
- SETTLE, on each rising edge:
  - `cnt` increments.
  - When `cnt` reaches `SETTLE_CYCLES−1`, capture the adder outputs into `res`/`res_cout`, compute `res_ovf`, set `res_id` = winner, pulse `res_valid`, and return to IDLE.
- Adder inputs: the op registers only. Requester inputs may change freely once ack has been seen.
- `res_ovf` rules (A, B = latched operands):
  - Add: A[3]==B[3] and res[3]≠A[3].
  - Sub: A[3]≠B[3] and res[3]≠A[3].
- `res_cout` is the raw adder carry. For subtract it is A+~B+1, so 1 means no borrow.
- Requests are sampled only in IDLE. `req` high during SETTLE, including the ack cycle, is ignored. A requester that keeps `req` high after its result is re-arbitrated normally.
- A `req` dropped before ack is never served. No abort path exists.
- Result fields hold their value until the next capture. `res_valid` is the only qualifier.

## Timing
- Reset values:
  - State IDLE, `cnt` = 0, `last_gnt` = 1, so requester 0 wins the first tie.
  - `ack0`, `ack1`, `busy`, `res_valid`, `res_id`, `res`, `res_cout`, `res_ovf` = 0; op registers = 0.
- `rst` mid-operation aborts the operation: no `res_valid`, no ack. State returns to IDLE on that edge. `rst` overrides all other inputs.
- Latency, for a request granted at edge E:
  - ack is high in cycle E..E+1.
  - `busy` is high from E to E+`SETTLE_CYCLES`.
  - `res_valid` is high in cycle E+`SETTLE_CYCLES`..E+`SETTLE_CYCLES`+1.
- Throughput:
  - The next grant can occur at edge E+`SETTLE_CYCLES`+1. The `res_valid` cycle is an IDLE cycle.
  - Maximum rate is one operation per `SETTLE_CYCLES`+1 cycles.
- Simultaneous events:
  - A new request arriving in the `res_valid` cycle is granted at the next edge.
  - `ack` and `res_valid` never coincide when `SETTLE_CYCLES` ≥ 1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then hold `req0`, `req1` both 0 for 10 cycles -> all outputs stay 0 and `busy` stays 0.
- `SETTLE_CYCLES`=2; `req0` with A=0101, B=0011, sel=0 -> `ack0` 1 cycle after the sampling edge; `res_valid` 2 cycles later with `res`=1000, `cout`=0, `ovf`=1, `id`=0.
- `req1` with A=1111, B=1010, sel=0 -> `res`=1001, `cout`=1, `ovf`=0, `id`=1. Then A=0111, B=1000, sel=1 -> `res`=1111, `cout`=0, `ovf`=1.
- After reset, hold `req0` and `req1` high continuously:
  - Grants alternate 0,1,0,1, one every 3 cycles.
  - `req0`: A=0010, B=0001, sub -> `res`=0001, `cout`=1.
  - `req1`: A=0001, B=0010, sub -> `res`=1111, `cout`=0, `ovf`=0.
- Change `a0` to 1111 in the cycle after `ack0` (original A=1001, B=1010, sub) -> the result still uses the latched values: `res`=1111, `ovf`=0.
- Assert `rst` for 1 cycle while `busy`=1 -> no `res_valid`. A following tie grants requester 0.
